// File: rtl/wb_pkg.sv
// Shared types and defaults for the Wishbone single-master interconnect.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    ERROR
  } wb_bus_state_t;

  // Default map: slave 0 = 64 KiB at 0x0000_0000, slave 1 = 256 MiB at 0x1000_0000.
  localparam logic [63:0] DEF_SLAVE_BASE = {32'h1000_0000, 32'h0000_0000};
  localparam logic [63:0] DEF_SLAVE_MASK = {32'hF000_0000, 32'hFFFF_0000};

  // Width of an encoded slave index; never below 1 so a single-slave build still has a vector.
  function automatic int slv_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address decoder: priority-resolved one-hot hit, encoded index, any-hit.
module wb_addr_decode
  import wb_pkg::*;
#(
  parameter int                               ADDR_WIDTH = 32,
  parameter int                               NUM_SLAVES = 2,
  parameter int                               IDX_W      = slv_idx_w(NUM_SLAVES),
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = DEF_SLAVE_MASK
) (
  input  logic [ADDR_WIDTH-1:0] adr_i,
  output logic [NUM_SLAVES-1:0] hit_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  any_o
);

  logic [NUM_SLAVES-1:0] raw_hit;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_cmp
    assign raw_hit[g] = (adr_i & SLAVE_MASK[g*ADDR_WIDTH +: ADDR_WIDTH])
                        == SLAVE_BASE[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Scan high to low so the lowest-index overlapping window wins.
  always_comb begin
    hit_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (raw_hit[i]) begin
        hit_o    = '0;
        hit_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_bus_mux.sv
// Single-master, N-slave Wishbone classic interconnect with registered decode,
// per-transfer timeout and bus-error termination for unmapped/hung accesses.
module wb_bus_mux
  import wb_pkg::*;
#(
  parameter int                               ADDR_WIDTH = 32,
  parameter int                               DATA_WIDTH = 32,
  parameter int                               NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = DEF_SLAVE_MASK,
  parameter int                               TIMEOUT    = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [ADDR_WIDTH-1:0]            M_ADR_O,
  input  logic [DATA_WIDTH-1:0]            M_DAT_O,
  input  logic                             M_WE_O,
  input  logic [DATA_WIDTH/8-1:0]          M_SEL_O,
  input  logic                             M_STB_O,
  input  logic                             M_CYC_O,
  output logic [DATA_WIDTH-1:0]            M_DAT_I,
  output logic                             M_ACK_I,
  output logic                             M_ERR_I,
  output logic [ADDR_WIDTH-1:0]            S_ADR_I,
  output logic [DATA_WIDTH-1:0]            S_DAT_I,
  output logic                             S_WE_I,
  output logic [DATA_WIDTH/8-1:0]          S_SEL_I,
  output logic [NUM_SLAVES-1:0]            S_STB_I,
  output logic [NUM_SLAVES-1:0]            S_CYC_I,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] S_DAT_O,
  input  logic [NUM_SLAVES-1:0]            S_ACK_O,
  output logic [7:0]                       err_cnt_o,
  output logic [ADDR_WIDTH-1:0]            err_adr_o
);

  localparam int IDX_W = slv_idx_w(NUM_SLAVES);
  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  wb_bus_state_t         state_q, state_d;
  logic [IDX_W-1:0]      sel_q, sel_d;
  logic [NUM_SLAVES-1:0] sel_oh_q, sel_oh_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  we_q, we_d;
  logic [SEL_W-1:0]      bsel_q, bsel_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] err_adr_q, err_adr_d;

  logic [NUM_SLAVES-1:0] dec_hit;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_any;
  logic [DATA_WIDTH-1:0] rd_dat;
  logic                  sel_ack;

  wb_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_SLAVES(NUM_SLAVES),
    .IDX_W     (IDX_W),
    .SLAVE_BASE(SLAVE_BASE),
    .SLAVE_MASK(SLAVE_MASK)
  ) u_dec (
    .adr_i(M_ADR_O),
    .hit_o(dec_hit),
    .idx_o(dec_idx),
    .any_o(dec_any)
  );

  assign S_ADR_I   = adr_q;
  assign S_DAT_I   = dat_q;
  assign S_WE_I    = we_q;
  assign S_SEL_I   = bsel_q;
  assign err_cnt_o = err_cnt_q;
  assign err_adr_o = err_adr_q;

  // Only the latched slave may terminate; ACKs from the rest are ignored.
  assign sel_ack = |(S_ACK_O & sel_oh_q);

  // Read-data mux keyed on the latched slave index.
  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == IDX_W'(i)) rd_dat = S_DAT_O[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state, slave fan-out and master termination.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    sel_oh_d  = sel_oh_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    bsel_d    = bsel_q;
    err_cnt_d = err_cnt_q;
    err_adr_d = err_adr_q;
    S_STB_I   = '0;
    S_CYC_I   = '0;
    M_ACK_I   = 1'b0;
    M_ERR_I   = 1'b0;
    M_DAT_I   = '0;

    case (state_q)
      IDLE: begin
        if (M_CYC_O && M_STB_O) begin
          adr_d  = M_ADR_O;
          dat_d  = M_DAT_O;
          we_d   = M_WE_O;
          bsel_d = M_SEL_O;
          if (dec_any) begin
            sel_d    = dec_idx;
            sel_oh_d = dec_hit;
            cnt_d    = '0;
            state_d  = ACTIVE;
          end else begin
            state_d = ERROR;
          end
        end
      end
      ACTIVE: begin
        M_DAT_I = rd_dat;
        if (!M_CYC_O) begin
          // Master abandoned the cycle: drop back quietly.
          state_d = IDLE;
        end else if (sel_ack) begin
          S_CYC_I = sel_oh_q;
          S_STB_I = sel_oh_q & {NUM_SLAVES{M_STB_O}};
          M_ACK_I = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Hung slave: strobes stay low so the slave sees the cycle end.
          M_ERR_I = 1'b1;
          state_d = IDLE;
        end else begin
          S_CYC_I = sel_oh_q;
          S_STB_I = sel_oh_q & {NUM_SLAVES{M_STB_O}};
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ERROR: begin
        M_ERR_I = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (M_ERR_I) begin
      err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
      err_adr_d = adr_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      sel_oh_q  <= '0;
      cnt_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      bsel_q    <= '0;
      err_cnt_q <= '0;
      err_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      sel_oh_q  <= sel_oh_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      bsel_q    <= bsel_d;
      err_cnt_q <= err_cnt_d;
      err_adr_q <= err_adr_d;
    end
  end

endmodule
